// File: rtl/simd_pkg.sv
// simd_pkg: shared SIMD datapath width, lane-mode codes, lanes-per-mode helper and default tag width
package simd_pkg;
  localparam int SIMD_WIDTH = 256;
  localparam int TAG_W_DEF = 5;
  localparam logic [2:0] MODE_8 = 3'd0;
  localparam logic [2:0] MODE_16 = 3'd1;
  localparam logic [2:0] MODE_32 = 3'd2;
  localparam logic [2:0] MODE_64 = 3'd3;
  localparam logic [2:0] MODE_128 = 3'd4;
  localparam logic [2:0] MODE_256 = 3'd5;
  function automatic int lanes_for_mode(input logic [2:0] mode);
    return (mode >= MODE_256) ? 1 : (32 >> mode);
  endfunction
endpackage

// File: rtl/simd_zero_mask.sv
// simd_zero_mask: per-lane zero flags and whole-word zero flag of a lane-partitioned result
// Ports: result_i (256b), mode_i (lane width code) -> mask_o (bit i = lane i zero, unused bits 0), all_zero_o
module simd_zero_mask
  import simd_pkg::*;
(
  input  logic [SIMD_WIDTH-1:0] result_i,
  input  logic [2:0]            mode_i,
  output logic [31:0]           mask_o,
  output logic                  all_zero_o
);
  logic [31:0] z8;
  logic [15:0] z16;
  logic [7:0]  z32;
  logic [3:0]  z64;
  logic [1:0]  z128;
  for (genvar i = 0; i < 32; i++) assign z8[i] = ~|result_i[8*i +: 8];
  for (genvar i = 0; i < 16; i++) assign z16[i] = ~|result_i[16*i +: 16];
  for (genvar i = 0; i < 8; i++) assign z32[i] = ~|result_i[32*i +: 32];
  for (genvar i = 0; i < 4; i++) assign z64[i] = ~|result_i[64*i +: 64];
  for (genvar i = 0; i < 2; i++) assign z128[i] = ~|result_i[128*i +: 128];
  assign all_zero_o = ~|result_i;
  // Codes above MODE_128 all mean a single 256b lane.
  always_comb begin
    mask_o = (mode_i == MODE_8)   ? z8 :
             (mode_i == MODE_16)  ? {16'b0, z16} :
             (mode_i == MODE_32)  ? {24'b0, z32} :
             (mode_i == MODE_64)  ? {28'b0, z64} :
             (mode_i == MODE_128) ? {30'b0, z128} : {31'b0, all_zero_o};
  end
endmodule

// File: rtl/simd_result_stage.sv
// simd_result_stage: FIFO buffer between the SIMD add/sub unit and writeback, with per-lane zero flags
// Ports: clk, rst_n (sync active-low); in_valid/in_ready/in_result/in_data_mode/in_tag upstream;
//        out_valid/out_ready/out_result/out_data_mode/out_tag/out_zero_mask/out_all_zero downstream; count occupancy.
// Macro SIMD_RES_ZERO_FLAGS_EN enables flag computation/storage; otherwise flags are tied to 0.
module simd_result_stage
  import simd_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int TAG_W = TAG_W_DEF
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [SIMD_WIDTH-1:0]      in_result,
  input  logic [2:0]                 in_data_mode,
  input  logic [TAG_W-1:0]           in_tag,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [SIMD_WIDTH-1:0]      out_result,
  output logic [2:0]                 out_data_mode,
  output logic [TAG_W-1:0]           out_tag,
  output logic [31:0]                out_zero_mask,
  output logic                       out_all_zero,
  output logic [$clog2(DEPTH):0]     count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  logic [SIMD_WIDTH-1:0] res_q [DEPTH];
  logic [2:0]            mode_q [DEPTH];
  logic [TAG_W-1:0]      tag_q [DEPTH];
  logic [AW-1:0]         wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]         count_q, count_d;
  logic                  push, pop;
  assign in_ready = count_q != CW'(DEPTH);
  assign out_valid = count_q != '0;
  assign push = in_valid && in_ready;
  assign pop = out_valid && out_ready;
  assign count = count_q;
  assign out_result = res_q[rd_ptr_q];
  assign out_data_mode = mode_q[rd_ptr_q];
  assign out_tag = tag_q[rd_ptr_q];
  // DEPTH is a power of two, so pointer wrap is natural overflow.
  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = pop ? rd_ptr_q + AW'(1) : rd_ptr_q;
    count_d = count_q + CW'(push) - CW'(pop);
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q <= count_d;
    end
  end
  always_ff @(posedge clk) begin
    if (push) begin
      res_q[wr_ptr_q] <= in_result;
      mode_q[wr_ptr_q] <= in_data_mode;
      tag_q[wr_ptr_q] <= in_tag;
    end
  end
`ifdef SIMD_RES_ZERO_FLAGS_EN
  logic [31:0] mask_q [DEPTH];
  logic        az_q [DEPTH];
  logic [31:0] in_mask;
  logic        in_az;
  simd_zero_mask u_zero_mask (
    .result_i   (in_result),
    .mode_i     (in_data_mode),
    .mask_o     (in_mask),
    .all_zero_o (in_az)
  );
  always_ff @(posedge clk) begin
    if (push) begin
      mask_q[wr_ptr_q] <= in_mask;
      az_q[wr_ptr_q] <= in_az;
    end
  end
  // Gated by out_valid so stale storage never shows flags while empty or after reset.
  assign out_zero_mask = out_valid ? mask_q[rd_ptr_q] : '0;
  assign out_all_zero = out_valid && az_q[rd_ptr_q];
`else
  assign out_zero_mask = '0;
  assign out_all_zero = 1'b0;
`endif
endmodule

// File: tb/tb_simd_result_stage.sv
// tb_simd_result_stage: directed self-checking bench with a queue model of the result stage
module tb_simd_result_stage;
  localparam int DEPTH = 2;
  logic clk = 0, rst_n = 0, in_valid = 0, out_ready = 0;
  logic [255:0] in_result = '0;
  logic [2:0] in_data_mode = '0;
  logic [4:0] in_tag = '0;
  logic in_ready, out_valid, out_all_zero;
  logic [255:0] out_result;
  logic [2:0] out_data_mode;
  logic [4:0] out_tag;
  logic [31:0] out_zero_mask;
  logic [1:0] count;
  int errors = 0, checks = 0, pops = 0, max_cnt = 0;
  bit started = 0, mon = 0;
  typedef struct { logic [255:0] r; logic [2:0] m; logic [4:0] t; } ent_t;
  ent_t q[$];

  simd_result_stage #(.DEPTH(DEPTH), .TAG_W(5)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_result(in_result), .in_data_mode(in_data_mode), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
    .out_data_mode(out_data_mode), .out_tag(out_tag), .out_zero_mask(out_zero_mask),
    .out_all_zero(out_all_zero), .count(count)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] exp_mask(input logic [255:0] r, input logic [2:0] m);
    logic [31:0] k = '0;
    int n = (m >= 5) ? 1 : (32 >> m);
    int w = 256 / n;
    logic [255:0] lm = (w == 256) ? {256{1'b1}} : ((256'd1 << w) - 256'd1);
    for (int i = 0; i < n; i++) k[i] = ((r >> (i * w)) & lm) == '0;
`ifndef SIMD_RES_ZERO_FLAGS_EN
    k = '0;
`endif
    return k;
  endfunction

  function automatic logic exp_az(input logic [255:0] r);
`ifdef SIMD_RES_ZERO_FLAGS_EN
    return r == '0;
`else
    return 1'b0;
`endif
  endfunction

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  always @(posedge clk) begin
    started <= 1;
    if (!rst_n) q.delete();
    else begin
      automatic bit do_pop = q.size() != 0 && out_ready;
      automatic bit do_push = in_valid && q.size() != DEPTH;
      if (do_pop) begin
        void'(q.pop_front());
        pops++;
      end
      if (do_push) q.push_back('{in_result, in_data_mode, in_tag});
    end
  end

  always @(negedge clk) begin
    if (started) begin
      chk("out_valid", 256'(out_valid), 256'(q.size() != 0));
      chk("in_ready", 256'(in_ready), 256'(q.size() != DEPTH));
      chk("count", 256'(count), 256'(q.size()));
      if (q.size() != 0) begin
        chk("out_result", out_result, q[0].r);
        chk("out_data_mode", 256'(out_data_mode), 256'(q[0].m));
        chk("out_tag", 256'(out_tag), 256'(q[0].t));
        chk("out_zero_mask", 256'(out_zero_mask), 256'(exp_mask(q[0].r, q[0].m)));
        chk("out_all_zero", 256'(out_all_zero), 256'(exp_az(q[0].r)));
      end
      if (mon && int'(count) > max_cnt) max_cnt = int'(count);
    end
  end

  logic [255:0] r;
  int p0;
  initial begin
    rst_n = 0; in_valid = 1; in_result = {8{32'hdeadbeef}}; in_tag = 5'd3;
    step(); step();
    rst_n = 1; in_valid = 0;
    @(negedge clk);
    chk("rst_out_valid", 256'(out_valid), 256'(0));
    chk("rst_count", 256'(count), 256'(0));
    chk("rst_in_ready", 256'(in_ready), 256'(1));
    chk("rst_zero_mask", 256'(out_zero_mask), 256'(0));
    chk("rst_all_zero", 256'(out_all_zero), 256'(0));
    step();
    r = {32{8'h01}}; r[31:24] = 8'h00;
    in_valid = 1; in_result = r; in_data_mode = 3'd0; in_tag = 5'd7;
    step();
    in_valid = 0;
    @(negedge clk);
    chk("t2_valid", 256'(out_valid), 256'(1));
    chk("t2_tag", 256'(out_tag), 256'(7));
`ifdef SIMD_RES_ZERO_FLAGS_EN
    chk("t2_mask", 256'(out_zero_mask), 256'(32'h0000_0008));
`else
    chk("t2_mask", 256'(out_zero_mask), 256'(0));
`endif
    chk("t2_all_zero", 256'(out_all_zero), 256'(0));
    out_ready = 1; step(); out_ready = 0;
    for (int i = 1; i <= 3; i++) begin
      in_valid = 1; in_tag = 5'(i); in_data_mode = 3'(i); in_result = {8{32'(i * 32'h01010101)}};
      step();
    end
    in_valid = 0;
    @(negedge clk);
    chk("t3_in_ready", 256'(in_ready), 256'(0));
    chk("t3_count", 256'(count), 256'(2));
    chk("t3_head_tag", 256'(out_tag), 256'(1));
    out_ready = 1; step();
    @(negedge clk);
    chk("t3_second_tag", 256'(out_tag), 256'(2));
    step();
    @(negedge clk);
    chk("t3_drained_ready", 256'(in_ready), 256'(1));
    chk("t3_drained_valid", 256'(out_valid), 256'(0));
    p0 = pops; mon = 1; max_cnt = 0;
    for (int i = 0; i < 16; i++) begin
      in_valid = 1; in_tag = 5'(i + 10); in_data_mode = 3'(i % 8);
      in_result = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      if (i % 4 == 1) in_result[63:0] = '0;
      step();
    end
    in_valid = 0;
    step();
    mon = 0;
    chk("t4_pops", 256'(pops - p0), 256'(16));
    chk("t4_max_count_le1", 256'(max_cnt <= 1), 256'(1));
    out_ready = 0;
    in_valid = 1; in_result = '0; in_data_mode = 3'd7; in_tag = 5'd9;
    step();
    in_valid = 0;
    @(negedge clk);
`ifdef SIMD_RES_ZERO_FLAGS_EN
    chk("t5_mask", 256'(out_zero_mask), 256'(32'h0000_0001));
    chk("t5_all_zero", 256'(out_all_zero), 256'(1));
`else
    chk("t5_mask", 256'(out_zero_mask), 256'(0));
    chk("t5_all_zero", 256'(out_all_zero), 256'(0));
`endif
    in_valid = 1; in_result = {64{4'ha}}; in_data_mode = 3'd4; in_tag = 5'd20;
    step();
    in_valid = 0;
    @(negedge clk);
    chk("t6_full_count", 256'(count), 256'(2));
    rst_n = 0; step(); rst_n = 1;
    @(negedge clk);
    chk("t6_rst_valid", 256'(out_valid), 256'(0));
    chk("t6_rst_count", 256'(count), 256'(0));
    in_valid = 1; in_result = {8{32'h1234_5678}}; in_data_mode = 3'd2; in_tag = 5'd11;
    step();
    in_valid = 0;
    @(negedge clk);
    chk("t6_push_valid", 256'(out_valid), 256'(1));
    chk("t6_push_tag", 256'(out_tag), 256'(11));
    out_ready = 1; step(); step();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
